// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: round-robin sharing of one single-port RAM between the CPU
// and a DMA/debug loader, with bounded DMA burst locking and address guarding.
module dmem_arbiter #(
  parameter int unsigned MAX_BURST = 8,
  parameter int unsigned ADDR_HI   = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic        dma_lock,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic [31:0] dma_rdata,
  output logic        dma_ack,
  output logic        addr_err,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic        ram_we,
  input  logic [31:0] ram_rdata
);

  typedef enum logic [1:0] {IDLE, DMA_LOCK, CPU_SLOT} state_t;

  localparam logic [7:0] MAX_B = 8'(MAX_BURST);

  state_t      state, state_nx;
  logic        rr_last, rr_last_nx;   // 1: DMA won the last granted cycle
  logic [7:0]  burst_cnt, burst_nx;
  logic        cpu_grant, dma_grant, granted;
  logic [31:0] win_addr, win_wdata, win_rdata;
  logic        win_we, win_ok;

  function automatic logic addr_check(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a[31:ADDR_HI+1] == '0);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_last   <= 1'b1;
      burst_cnt <= '0;
      addr_err  <= 1'b0;
    end else begin
      state     <= state_nx;
      rr_last   <= rr_last_nx;
      burst_cnt <= burst_nx;
      addr_err  <= granted & ~win_ok;
    end
  end

  // Grants are forced low in reset so nothing is acked or written in that cycle.
  always_comb begin
    cpu_grant = 1'b0;
    dma_grant = 1'b0;
    state_nx  = state;
    burst_nx  = burst_cnt;
    if (!rst) begin
      unique case (state)
        IDLE: begin
          if (cpu_req && dma_req) begin
            cpu_grant = rr_last;
            dma_grant = ~rr_last;
          end else begin
            cpu_grant = cpu_req;
            dma_grant = dma_req;
          end
          if (dma_grant && dma_lock) begin
            state_nx = DMA_LOCK;
            burst_nx = 8'd1;
          end
        end
        DMA_LOCK: begin
          dma_grant = dma_req;
          if (dma_grant) begin
            burst_nx = (burst_cnt >= MAX_B) ? MAX_B : burst_cnt + 8'd1;
            if (!dma_lock)
              state_nx = IDLE;
            else if ((burst_nx >= MAX_B) && cpu_req)
              state_nx = CPU_SLOT;
          end else if ((burst_cnt >= MAX_B) && cpu_req) begin
            state_nx = CPU_SLOT;
          end
        end
        CPU_SLOT: begin
          cpu_grant = cpu_req;
          if (dma_lock) begin
            state_nx = DMA_LOCK;
            burst_nx = '0;
          end else begin
            state_nx = IDLE;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    rr_last_nx = rr_last;
    if (cpu_grant)
      rr_last_nx = 1'b0;
    else if (dma_grant)
      rr_last_nx = 1'b1;
  end

  always_comb begin
    granted   = cpu_grant | dma_grant;
    win_addr  = dma_grant ? dma_addr  : cpu_addr;
    win_wdata = dma_grant ? dma_wdata : cpu_wdata;
    win_we    = dma_grant ? dma_we    : cpu_we;
    win_ok    = addr_check(win_addr);

    ram_addr  = '0;
    ram_wdata = '0;
    ram_we    = 1'b0;
    if (granted) begin
      ram_addr[ADDR_HI:2] = win_addr[ADDR_HI:2];
      ram_wdata           = win_wdata;
      ram_we              = win_we & win_ok;
    end

    win_rdata = win_ok ? ram_rdata : '0;
    cpu_rdata = cpu_grant ? win_rdata : '0;
    dma_rdata = dma_grant ? win_rdata : '0;
  end

  assign cpu_stall = cpu_req & ~cpu_grant & ~rst;
  assign dma_ack   = dma_grant;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed CPU/DMA traffic against a behavioural
// 32-word RAM; expected grants are queued in order and checked by a monitor.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        dma_req, dma_we, dma_lock;
  logic [31:0] dma_addr, dma_wdata, dma_rdata;
  logic        dma_ack, addr_err;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic        ram_we;

  logic        mem_init;
  logic [31:0] mem [32];

  int checks = 0;
  int fails  = 0;

  typedef struct {
    bit          dma;
    bit          we;
    logic [31:0] addr;
    bit          chk_rd;
    logic [31:0] rd;
    bit          bad;
  } exp_t;

  exp_t q[$];

  dmem_arbiter #(.MAX_BURST(8), .ADDR_HI(6)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_lock(dma_lock), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .addr_err(addr_err),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'hA500_0000 + 32'(i);
    end else if (ram_we) begin
      mem[ram_addr[6:2]] <= ram_wdata;
    end
  end
  assign ram_rdata = mem[ram_addr[6:2]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void expect_tx(input bit dma, input bit we, input logic [31:0] addr,
                                    input bit chk_rd, input logic [31:0] rd, input bit bad);
    exp_t e;
    e.dma = dma; e.we = we; e.addr = addr; e.chk_rd = chk_rd; e.rd = rd; e.bad = bad;
    q.push_back(e);
  endfunction

  // Called at posedge+1; holds the request until served, returns at posedge+1.
  task automatic cpu_do(input logic we, input logic [31:0] a, input logic [31:0] d,
                        output int waits);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    waits = 0;
    do begin @(negedge clk); waits++; end while (cpu_stall && waits < 64);
    if (cpu_stall) begin
      checks++; fails++;
      $display("FAIL cpu_timeout: still stalled after %0d cycles, required served", waits);
    end
    @(posedge clk); #1;
    cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic dma_do(input logic we, input logic lock, input logic [31:0] a,
                        input logic [31:0] d, output int waits);
    dma_req = 1'b1; dma_we = we; dma_lock = lock; dma_addr = a; dma_wdata = d;
    waits = 0;
    do begin @(negedge clk); waits++; end while (!dma_ack && waits < 64);
    if (!dma_ack) begin
      checks++; fails++;
      $display("FAIL dma_timeout: no ack after %0d cycles, required ack", waits);
    end
    @(posedge clk); #1;
    dma_req = 1'b0; dma_we = 1'b0; dma_lock = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    logic cg, dg, exp_err;
    exp_err = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_err = 1'b0;
      end else begin
        chk1("addr_err", addr_err, exp_err);
        cg = cpu_req & ~cpu_stall;
        dg = dma_ack;
        exp_err = 1'b0;
        if (cg || dg) begin
          chk1("single_grant", cg & dg, 1'b0);
          if (q.size() == 0) begin
            checks++; fails++;
            $display("FAIL unexpected_grant: cpu=%b dma=%b, required no grant", cg, dg);
          end else begin
            e = q.pop_front();
            chk1("grant_owner_dma", dg, e.dma);
            chk1("ram_we", ram_we, e.we);
            chk("ram_addr", ram_addr, e.addr);
            if (e.chk_rd) chk("winner_rdata", dg ? dma_rdata : cpu_rdata, e.rd);
            chk("loser_rdata", dg ? cpu_rdata : dma_rdata, 32'h0);
            exp_err = e.bad;
          end
        end else begin
          chk1("idle_ram_we", ram_we, 1'b0);
          chk("idle_ram_addr", ram_addr, 32'h0);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int w, w2, wsum;
    rst = 1'b1; mem_init = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h4; cpu_wdata = 32'h1234;
    dma_req = 1'b1; dma_we = 1'b1; dma_lock = 1'b1; dma_addr = 32'h8; dma_wdata = 32'h5678;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("rst_ram_we", ram_we, 1'b0);
    chk1("rst_cpu_stall", cpu_stall, 1'b0);
    chk1("rst_dma_ack", dma_ack, 1'b0);
    chk1("rst_addr_err", addr_err, 1'b0);
    @(posedge clk); #1;
    mem_init = 1'b0; rst = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; dma_req = 1'b0; dma_we = 1'b0; dma_lock = 1'b0;

    // CPU alone: store then load
    expect_tx(0, 1, 32'h10, 0, 32'h0, 0);
    expect_tx(0, 0, 32'h10, 1, 32'hDEAD_BEEF, 0);
    cpu_do(1'b1, 32'h10, 32'hDEAD_BEEF, w);
    chk("cpu_alone_store_wait", w, 1);
    cpu_do(1'b0, 32'h10, 32'h0, w);
    chk("cpu_alone_load_wait", w, 1);

    // Contention without lock: C, D, C, D
    do_reset();
    expect_tx(0, 0, 32'h10, 1, 32'hDEAD_BEEF, 0);
    expect_tx(1, 0, 32'h14, 1, 32'hA500_0005, 0);
    expect_tx(0, 0, 32'h10, 1, 32'hDEAD_BEEF, 0);
    expect_tx(1, 0, 32'h18, 1, 32'hA500_0006, 0);
    fork
      begin
        cpu_do(1'b0, 32'h10, 32'h0, w);
        cpu_do(1'b0, 32'h10, 32'h0, w);
      end
      begin
        dma_do(1'b0, 1'b0, 32'h14, 32'h0, w2);
        dma_do(1'b0, 1'b0, 32'h18, 32'h0, w2);
      end
    join

    // Locked burst with a waiting CPU: 8 D, one CPU slot, 4 D
    for (int i = 0; i < 8; i++) expect_tx(1, 1, 32'(4 * i), 0, 32'h0, 0);
    expect_tx(0, 0, 32'h10, 1, 32'hB000_0004, 0);
    for (int i = 8; i < 12; i++) expect_tx(1, 1, 32'(4 * i), 0, 32'h0, 0);
    fork
      begin
        for (int i = 0; i < 12; i++)
          dma_do(1'b1, (i < 11), 32'(4 * i), 32'hB000_0000 + 32'(i), w2);
      end
      begin
        @(posedge clk); #1;
        cpu_do(1'b0, 32'h10, 32'h0, w);
        chk("burst_cpu_wait", w, 8);
      end
    join

    // Locked burst with idle CPU: 12 back-to-back acks
    wsum = 0;
    for (int i = 16; i < 28; i++) expect_tx(1, 1, 32'(4 * i), 0, 32'h0, 0);
    for (int i = 16; i < 28; i++) begin
      dma_do(1'b1, (i < 27), 32'(4 * i), 32'hC000_0000 + 32'(i), w2);
      wsum += w2;
    end
    chk("idle_cpu_burst_cycles", wsum, 12);

    // Bad addresses: served, no write, read returns 0, error pulse follows
    expect_tx(0, 0, 32'h10, 0, 32'h0, 1);
    expect_tx(1, 0, 32'h00, 0, 32'h0, 1);
    expect_tx(0, 0, 32'h10, 1, 32'h0, 1);
    expect_tx(0, 0, 32'h10, 1, 32'hB000_0004, 0);
    cpu_do(1'b1, 32'h12, 32'h1111_1111, w);
    chk("bad_cpu_wait", w, 1);
    dma_do(1'b1, 1'b0, 32'h80, 32'h2222_2222, w2);
    chk("bad_dma_wait", w2, 1);
    cpu_do(1'b0, 32'h13, 32'h0, w);
    cpu_do(1'b0, 32'h10, 32'h0, w);
    chk("bad_mem_word4", mem[4], 32'hB000_0004);
    chk("bad_mem_word0", mem[0], 32'hB000_0000);

    // Reset in the middle of a locked burst
    do_reset();
    for (int i = 28; i < 31; i++) expect_tx(1, 1, 32'(4 * i), 0, 32'h0, 0);
    for (int i = 28; i < 31; i++)
      dma_do(1'b1, 1'b1, 32'(4 * i), 32'hD000_0000 + 32'(i), w2);
    dma_req = 1'b1; dma_we = 1'b1; dma_lock = 1'b1;
    dma_addr = 32'h7C; dma_wdata = 32'hD000_001F;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0;
    rst = 1'b1;
    @(negedge clk);
    chk1("midrst_ram_we", ram_we, 1'b0);
    chk1("midrst_dma_ack", dma_ack, 1'b0);
    chk1("midrst_cpu_stall", cpu_stall, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    dma_req = 1'b0; dma_we = 1'b0; dma_lock = 1'b0; cpu_req = 1'b0;
    expect_tx(0, 0, 32'h7C, 1, 32'hA500_001F, 0);
    expect_tx(1, 0, 32'h70, 1, 32'hD000_001C, 0);
    fork
      cpu_do(1'b0, 32'h7C, 32'h0, w);
      dma_do(1'b0, 1'b0, 32'h70, 32'h0, w2);
    join
    chk("midrst_cpu_first", w, 1);
    chk("midrst_dma_second", w2, 2);

    repeat (2) @(posedge clk);
    for (int i = 0; i < 12; i++) chk("burst_mem", mem[i], 32'hB000_0000 + 32'(i));
    for (int i = 16; i < 28; i++) chk("idle_burst_mem", mem[i], 32'hC000_0000 + 32'(i));
    chk("midrst_word31", mem[31], 32'hA500_001F);
    chk("scoreboard_drained", 32'(q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
